// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: MDU_Control encodings, default cycle counts and
// the launch-code decode used by the MDU, the controller decoder and the
// hazard unit.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu).
package e_mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'b0000;
    localparam logic [3:0] MDU_MULT  = 4'b0001;
    localparam logic [3:0] MDU_MULTU = 4'b0010;
    localparam logic [3:0] MDU_DIV   = 4'b0011;
    localparam logic [3:0] MDU_DIVU  = 4'b0100;
    localparam logic [3:0] MDU_MFHI  = 4'b0101;
    localparam logic [3:0] MDU_MFLO  = 4'b0110;
    localparam logic [3:0] MDU_MTHI  = 4'b0111;
    localparam logic [3:0] MDU_MTLO  = 4'b1000;
    localparam logic [3:0] MDU_MADD  = 4'b1001;
    localparam logic [3:0] MDU_MADDU = 4'b1010;
    localparam logic [3:0] MDU_MSUB  = 4'b1011;
    localparam logic [3:0] MDU_MSUBU = 4'b1100;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // True for codes that start a multi-cycle operation when Start is high.
    function automatic logic mdu_is_launch(input logic [3:0] code);
        logic w_hit;
        w_hit = (code == MDU_MULT) || (code == MDU_MULTU) ||
                (code == MDU_DIV)  || (code == MDU_DIVU);
`ifdef MDU_MADD_EN
        w_hit = w_hit || (code == MDU_MADD) || (code == MDU_MADDU) ||
                (code == MDU_MSUB) || (code == MDU_MSUBU);
`endif
        return w_hit;
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit product / quotient / remainder generation for the MDU.
// Result layout is {HI, LO}. Division by zero raises o_div_zero and the
// caller keeps HI/LO unchanged. Optional feature macro: MDU_MADD_EN.
module e_mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctrl,
`ifdef MDU_MADD_EN
    input  logic [63:0] i_acc,
`endif
    output logic [63:0] o_res,
    output logic        o_div_zero
);

    logic [63:0] w_sa, w_sb, w_sprod, w_uprod;
    logic [31:0] w_abs_a, w_abs_b, w_ub_safe, w_sb_safe;
    logic [31:0] w_uquo, w_urem, w_mquo, w_mrem, w_squo, w_srem;

    // Products: sign-extending to 64 bits gives the signed product modulo 2^64.
    assign w_sa    = {{32{i_a[31]}}, i_a};
    assign w_sb    = {{32{i_b[31]}}, i_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    // Division: a zero divisor is replaced by 1 only to keep the divider
    // X-free; the result is discarded via o_div_zero.
    assign w_ub_safe = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_uquo    = i_a / w_ub_safe;
    assign w_urem    = i_a % w_ub_safe;

    // Signed division on magnitudes; 0x80000000 stays 0x80000000 as an
    // unsigned magnitude, which yields the required overflow result.
    assign w_abs_a   = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_abs_b   = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_sb_safe = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_mquo    = w_abs_a / w_sb_safe;
    assign w_mrem    = w_abs_a % w_sb_safe;
    assign w_squo    = (i_a[31] ^ i_b[31]) ? (~w_mquo + 32'd1) : w_mquo;
    assign w_srem    = i_a[31] ? (~w_mrem + 32'd1) : w_mrem;

    // Select the result for the requested operation.
    always_comb begin
        o_res      = 64'd0;
        o_div_zero = 1'b0;
        case (i_ctrl)
            MDU_MULT:  o_res = w_sprod;
            MDU_MULTU: o_res = w_uprod;
            MDU_DIV: begin
                o_res      = {w_srem, w_squo};
                o_div_zero = (i_b == 32'd0);
            end
            MDU_DIVU: begin
                o_res      = {w_urem, w_uquo};
                o_div_zero = (i_b == 32'd0);
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  o_res = i_acc + w_sprod;
            MDU_MADDU: o_res = i_acc + w_uprod;
            MDU_MSUB:  o_res = i_acc - w_sprod;
            MDU_MSUBU: o_res = i_acc - w_uprod;
`endif
            default:   o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: two-state FSM, busy counter, shadow result
// registers and architectural HI/LO. Optional feature macro: MDU_MADD_EN.
//
// Handshake: Start is a one-cycle launch strobe. It is accepted only when
// Busy is low and MDU_Control is a launch code; otherwise it is ignored.
// Busy is registered; the hazard unit stalls D on Start|Busy. Results land
// in HI/LO at the edge that ends the last Busy cycle.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDU_Control,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Result,
    output logic [0:0]  o_dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_hi, r_lo, r_hi_s, r_lo_s;
    logic        r_div_zero;
    logic [63:0] w_res;
    logic        w_div_zero;
    logic        w_is_div;

    e_mdu_arith u_arith (
        .i_a        (SrcA),
        .i_b        (SrcB),
        .i_ctrl     (MDU_Control),
`ifdef MDU_MADD_EN
        .i_acc      ({r_hi, r_lo}),
`endif
        .o_res      (w_res),
        .o_div_zero (w_div_zero)
    );

    assign w_is_div = (MDU_Control == MDU_DIV) || (MDU_Control == MDU_DIVU);

    // FSM, counter, shadow capture at launch and HI/LO commit / move-to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_hi_s     <= 32'd0;
            r_lo_s     <= 32'd0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        if (mdu_is_launch(MDU_Control)) begin
                            r_hi_s     <= w_res[63:32];
                            r_lo_s     <= w_res[31:0];
                            r_div_zero <= w_div_zero;
                            r_cnt      <= w_is_div ? DIV_CYCLES[31:0] : MULT_CYCLES[31:0];
                            r_state    <= ST_RUN;
                        end
                    end else if (MDU_Control == MDU_MTHI) begin
                        r_hi <= SrcA;
                    end else if (MDU_Control == MDU_MTLO) begin
                        r_lo <= SrcA;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 32'd1;
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_IDLE;
                        if (!r_div_zero) begin
                            r_hi <= r_hi_s;
                            r_lo <= r_lo_s;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy        = (r_state == ST_RUN);
    assign HI          = r_hi;
    assign LO          = r_lo;
    assign o_dbg_state = r_state;

    // mfhi/mflo read path; zero for every other code.
    always_comb begin
        MDU_Result = 32'd0;
        if (MDU_Control == MDU_MFHI)      MDU_Result = r_hi;
        else if (MDU_Control == MDU_MFLO) MDU_Result = r_lo;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed, table-driven bench for e_mdu with hand-computed expectations,
// plus hand-written sequences for move-to, ignored Start and mid-op reset.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_a, src_b;
  logic [3:0]  ctrl;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, mdu_result;
  logic [0:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .SrcA        (src_a),
    .SrcB        (src_b),
    .MDU_Control (ctrl),
    .Start       (start),
    .Busy        (busy),
    .HI          (hi),
    .LO          (lo),
    .MDU_Result  (mdu_result),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: single-cycle mthi / mtlo
  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    ctrl  = op;
    src_a = v;
    start = 1'b0;
    tick();
    ctrl  = MDU_NONE;
  endtask

  // driver: one-cycle Start strobe; operands are scrambled afterwards
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ctrl  = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctrl  = MDU_NONE;
    src_a = $urandom_range(0, 32'hFFFF);
    src_b = $urandom_range(0, 32'hFFFF);
  endtask

  // counts Busy cycles at negedges until Busy drops (bounded)
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    src_a = '0;
    src_b = '0;
    ctrl  = MDU_NONE;
    start = 1'b0;

    vecs.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,        5,  32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{MDU_DIVU,  32'd7,        32'd0,        32'h11, 32'h22,       10, 32'h00000011, 32'h00000022});
    vecs.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,        10, 32'h00000000, 32'h80000000});
    vecs.push_back('{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,        10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{MDU_DIVU,  32'd100,      32'd7,        32'h0,  32'h0,        10, 32'h00000002, 32'h0000000E});
    vecs.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,        5,  32'h40000000, 32'h00000000});
    vecs.push_back('{MDU_DIV,   32'd5,        32'd0,        32'h33, 32'h44,       10, 32'h00000033, 32'h00000044});
`ifdef MDU_MADD_EN
    vecs.push_back('{MDU_MADDU, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 5,  32'h00000001, 32'h00000000});
    vecs.push_back('{MDU_MSUB,  32'd1,        32'd1,        32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{MDU_MADD,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,        5,  32'h00000000, 32'h00000003});
    vecs.push_back('{MDU_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,        5,  32'h00000001, 32'hFFFFFFFF});
`else
    vecs.push_back('{MDU_MADD,  32'd1,        32'd1,        32'h7,  32'h8,        0,  32'h00000007, 32'h00000008});
    vecs.push_back('{MDU_MSUBU, 32'd1,        32'd1,        32'h9,  32'hA,        0,  32'h00000009, 32'h0000000A});
`endif
    vecs.push_back('{4'b1111,   32'd3,        32'd3,        32'h1,  32'h2,        0,  32'h00000001, 32'h00000002});

    // reset state
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_result", mdu_result, 32'd0);
    tick();

    // table-driven vectors
    foreach (vecs[i]) begin
      move_to(MDU_MTHI, vecs[i].pre_hi);
      move_to(MDU_MTLO, vecs[i].pre_lo);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      count_busy(nb);
      chk($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      ctrl = MDU_MFHI;
      #1;
      chk($sformatf("vec%0d_mfhi", i), mdu_result, vecs[i].exp_hi);
      ctrl = MDU_MFLO;
      #1;
      chk($sformatf("vec%0d_mflo", i), mdu_result, vecs[i].exp_lo);
      ctrl = MDU_NONE;
      #1;
      chk($sformatf("vec%0d_result_none", i), mdu_result, 32'd0);
      tick();
    end

    // mthi then mtlo on consecutive cycles
    ctrl  = MDU_MTHI;
    src_a = 32'hABCD0000;
    tick();
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    ctrl  = MDU_MTLO;
    src_a = 32'h00001234;
    tick();
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    ctrl = MDU_NONE;
    chk("mt_hi", hi, 32'hABCD0000);
    chk("mt_lo", lo, 32'h00001234);

    // Start and mthi during an active mult are ignored
    move_to(MDU_MTHI, 32'd0);
    move_to(MDU_MTLO, 32'd0);
    launch(MDU_MULT, 32'd3, 32'd4);
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (k == 1) begin
        start = 1'b1; ctrl = MDU_DIV; src_a = 32'd100; src_b = 32'd3;
      end else if (k == 2) begin
        start = 1'b0; ctrl = MDU_MTHI; src_a = 32'hDEAD;
      end else if (k == 3) begin
        ctrl = MDU_NONE;
      end
    end
    chk("busy_start_cycles", nb, 32'd5);
    chk("busy_start_hi", hi, 32'd0);
    chk("busy_start_lo", lo, 32'd12);
    repeat (12) @(negedge clk);
    chk("busy_start_no_second_op", {31'd0, busy}, 32'd0);
    chk("busy_start_lo_kept", lo, 32'd12);
    tick();

    // reset in the 3rd Busy cycle of a div aborts it
    move_to(MDU_MTHI, 32'h55);
    move_to(MDU_MTLO, 32'h66);
    launch(MDU_DIV, 32'd9, 32'd2);
    tick();
    tick();
    chk("abort_in_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_commit_hi", hi, 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
